// File: rtl/mem_sweep_pkg.sv
// Shared types and constants for the memory sweep engine.
// The two step functions are the single definition of the LFSR and MISR recurrences.
package mem_sweep_pkg;

   typedef enum logic [1:0] {
      MODE_FILL  = 2'b00,
      MODE_CHECK = 2'b01,
      MODE_SIGN  = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
   localparam logic [31:0] MISR_INIT = 32'hFFFF_FFFF;

   // Galois form, shifting right: the bit falling out of bit 0 feeds back through the taps.
   function automatic logic [31:0] lfsr_next(input logic [31:0] v);
      return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
   endfunction

   function automatic logic [31:0] misr_fold(input logic [31:0] m, input logic [31:0] d);
      return {m[30:0], 1'b0} ^ (m[31] ? MISR_POLY : 32'h0) ^ d;
   endfunction

endpackage

// File: rtl/sweep_lfsr.sv
// Pattern generator shared by FILL and CHECK so both sweeps see the same stream for a seed.
// A zero seed would lock the LFSR at zero, so it is replaced by 1 on load.
module sweep_lfsr
   import mem_sweep_pkg::*;
#(
   parameter int OUT_W = 18
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [31:0]      seed,
   output logic [OUT_W-1:0] value
);

   logic [31:0] lfsr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= 32'h1;
      end else if (load) begin
         lfsr_q <= (seed == 32'h0) ? 32'h1 : seed;
      end else if (step) begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mem_sweep_engine.sv
// Sweeps a block RAM with no write enable: FILL writes an LFSR pattern, CHECK reads it back
// and counts mismatches, SIGN folds every read word into a 32-bit MISR.
module mem_sweep_engine
   import mem_sweep_pkg::*;
#(
   parameter int WID_MEM   = 18,
   parameter int DEPTH_MEM = 4096,
   parameter int ADDR_W    = 12,
   parameter int READ_LAT  = 1,
   parameter int ERR_W     = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [31:0]        seed,
   output logic [ADDR_W-1:0]  raddr,
   output logic [ADDR_W-1:0]  waddr,
   output logic [WID_MEM-1:0] din,
   input  logic [WID_MEM-1:0] dout,
   output logic               busy,
   output logic               done,
   output logic               err_flag,
   output logic [ERR_W-1:0]   err_count,
   output logic [ADDR_W-1:0]  first_err_addr,
   output logic [31:0]        signature,
   output logic [2:0]         dbg_state
);

   localparam logic [ADDR_W-1:0] SCR       = ADDR_W'(DEPTH_MEM - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 2);
   localparam int                DRAIN_W   = $clog2(READ_LAT + 2);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(READ_LAT);

   // Handshake: start is a request sampled only in IDLE (mode 11 never accepted); busy is high
   // from the accepting edge until the sweep ends; done pulses for one cycle as busy falls.

   state_e              state_q, state_d;
   mode_e               mode_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DRAIN_W-1:0]  drain_q;
   logic [WID_MEM-1:0]  pattern;
   logic [31:0]         misr_q, misr_nxt;

   logic                accept, fill_en, issue, busy_d, done_d, last_addr;
   logic                cmp_en, chk_miss, sign_hit;

   // Read-side pipeline: expected word and address ride alongside the RAM read latency.
   logic                pipe_v    [READ_LAT+1];
   logic [WID_MEM-1:0]  pipe_exp  [READ_LAT+1];
   logic [ADDR_W-1:0]   pipe_addr [READ_LAT+1];

   assign last_addr = (addr_q == LAST_ADDR);
   assign dbg_state = state_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start && (mode_e'(mode) != MODE_RSVD)) begin
               state_d = (mode_e'(mode) == MODE_FILL) ? ST_FILL : ST_READ;
            end
         end
         ST_FILL:  if (last_addr) state_d = ST_DONE;
         ST_READ:  if (last_addr) state_d = ST_DRAIN;
         ST_DRAIN: if (drain_q == DRAIN_LAST) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / controls ----------------
   always_comb begin
      accept  = 1'b0;
      fill_en = 1'b0;
      issue   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) accept = 1'b1;
      if (state_q == ST_FILL) fill_en = 1'b1;
      if (state_q == ST_READ) issue = 1'b1;
      if ((state_d == ST_FILL) || (state_d == ST_READ) || (state_d == ST_DRAIN)) busy_d = 1'b1;
      if (state_d == ST_DONE) done_d = 1'b1;
   end

   sweep_lfsr #(.OUT_W(WID_MEM)) u_lfsr (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .step  (fill_en | issue),
      .seed  (seed),
      .value (pattern)
   );

   // ---------------- sweep address, memory ports, status ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q  <= MODE_FILL;
         addr_q  <= '0;
         drain_q <= '0;
         raddr   <= '0;
         waddr   <= SCR;
         din     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
         if (accept) begin
            mode_q <= mode_e'(mode);
            addr_q <= '0;
         end else if (fill_en || issue) begin
            addr_q <= addr_q + 1'b1;
         end
         drain_q <= (state_q == ST_DRAIN) ? drain_q + 1'b1 : '0;
         // Writes land on the scratch word with zero data unless a FILL word is being issued.
         waddr <= fill_en ? addr_q  : SCR;
         din   <= fill_en ? pattern : '0;
         if (issue) raddr <= addr_q;
      end
   end

   // ---------------- read pipeline ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i <= READ_LAT; i++) begin
            pipe_v[i]    <= 1'b0;
            pipe_exp[i]  <= '0;
            pipe_addr[i] <= '0;
         end
      end else begin
         pipe_v[0]    <= issue;
         pipe_exp[0]  <= pattern;
         pipe_addr[0] <= addr_q;
         for (int i = 1; i <= READ_LAT; i++) begin
            pipe_v[i]    <= pipe_v[i-1];
            pipe_exp[i]  <= pipe_exp[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
         end
      end
   end

   assign cmp_en   = pipe_v[READ_LAT];
   assign chk_miss = cmp_en && (mode_q == MODE_CHECK) && (dout != pipe_exp[READ_LAT]);
   assign sign_hit = cmp_en && (mode_q == MODE_SIGN);
   assign misr_nxt = sign_hit ? misr_fold(misr_q, 32'(dout)) : misr_q;

   // ---------------- CHECK error tracking ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_flag       <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (accept && (mode_e'(mode) == MODE_CHECK)) begin
         err_flag       <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else if (chk_miss) begin
         if (err_count != '1) err_count <= err_count + 1'b1;
         if (!err_flag) begin
            err_flag       <= 1'b1;
            first_err_addr <= pipe_addr[READ_LAT];
         end
      end
   end

   // ---------------- SIGN MISR ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         misr_q    <= '0;
         signature <= '0;
      end else begin
         if (accept && (mode_e'(mode) == MODE_SIGN)) begin
            misr_q <= MISR_INIT;
         end else begin
            misr_q <= misr_nxt;
         end
         // The final word is folded on the same edge that enters DONE.
         if ((state_d == ST_DONE) && (mode_q == MODE_SIGN)) signature <= misr_nxt;
      end
   end

endmodule

// File: tb/tb_mem_sweep_engine.sv
// Directed bench for mem_sweep_engine with a registered-read RAM model (16 x 18, latency 1).
module tb_mem_sweep_engine;

  localparam int WID   = 18;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RL    = 1;
  localparam int EW    = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic [31:0]     seed = 32'h0;
  logic [AW-1:0]   raddr, waddr, first_err_addr;
  logic [WID-1:0]  din, dout;
  logic            busy, done, err_flag;
  logic [EW-1:0]   err_count;
  logic [31:0]     signature;
  logic [2:0]      dbg_state;

  logic [WID-1:0]  mem [DEPTH];
  logic            bd_en = 1'b0;
  logic [AW-1:0]   bd_addr = '0;
  logic [WID-1:0]  bd_data = '0;

  logic [31:0]     exp_q[$];
  int              checks = 0;
  int              failures = 0;
  int              bcyc, dcnt, cyc;
  logic [31:0]     exp_sig;
  logic [WID-1:0]  w;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_sweep_engine #(
    .WID_MEM(WID), .DEPTH_MEM(DEPTH), .ADDR_W(AW), .READ_LAT(RL), .ERR_W(EW)
  ) dut (
    .clk            (clk),
    .reset          (rst_n),
    .start          (start),
    .mode           (mode),
    .seed           (seed),
    .raddr          (raddr),
    .waddr          (waddr),
    .din            (din),
    .dout           (dout),
    .busy           (busy),
    .done           (done),
    .err_flag       (err_flag),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .signature      (signature),
    .dbg_state      (dbg_state)
  );

  // RAM model: unconditional write every clock, registered read; backdoor write wins.
  always @(posedge clk) begin
    mem[waddr] <= din;
    if (bd_en) mem[bd_addr] <= bd_data;
    dout <= mem[raddr];
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] misr_ref(input logic [31:0] m, input logic [31:0] d);
    logic [31:0] r;
    r = {m[30:0], 1'b0};
    if (m[31]) r = r ^ 32'h04C11DB7;
    return r ^ d;
  endfunction

  // ---------------- drivers ----------------
  task automatic run_sweep(input logic [1:0] m, input logic [31:0] s, input bit pulse_mid,
                           output int busy_cycles, output int done_pulses);
    @(negedge clk);
    start = 1'b1; mode = m; seed = s;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    done_pulses = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) busy_cycles++;
      if (done) done_pulses++;
      if (pulse_mid && i == 3) begin
        start = 1'b1; mode = 2'b00; seed = 32'h5;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [WID-1:0] d);
    @(negedge clk);
    bd_en = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_en = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Test 1: reset asserted mid-clock takes effect at once.
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_done", done, 0);
    check("t1_waddr", waddr, 15);
    check("t1_din", din, 0);
    check("t1_raddr", raddr, 0);
    check("t1_state", dbg_state, 0);
    check("t1_errcnt", err_count, 0);
    check("t1_errflag", err_flag, 0);
    check("t1_sig", signature, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Test 2: FILL seed 1 then CHECK seed 1.
    run_sweep(2'b00, 32'h1, 1'b0, bcyc, dcnt);
    check("t2_fill_busy", bcyc, 15);
    check("t2_fill_done", dcnt, 1);
    check("t2_mem0", mem[0], 18'h1);
    check("t2_mem1", mem[1], 18'h3);
    check("t2_mem2", mem[2], 18'h2);
    check("t2_mem15", mem[15], 18'h0);
    run_sweep(2'b01, 32'h1, 1'b0, bcyc, dcnt);
    check("t2_chk_busy", bcyc, 17);
    check("t2_chk_done", dcnt, 1);
    check("t2_errcnt", err_count, 0);
    check("t2_errflag", err_flag, 0);
    check("t2_mem15_after", mem[15], 18'h0);

    // Test 3: single corrupted word is located.
    run_sweep(2'b00, 32'h1, 1'b0, bcyc, dcnt);
    w = mem[5] ^ 18'h1;
    bd_write(4'd5, w);
    run_sweep(2'b01, 32'h1, 1'b0, bcyc, dcnt);
    check("t3_errcnt", err_count, 1);
    check("t3_first", first_err_addr, 5);
    check("t3_errflag", err_flag, 1);

    // Test 4: seed 0 behaves as seed 1; CHECK start clears old errors.
    run_sweep(2'b00, 32'h0, 1'b0, bcyc, dcnt);
    check("t4_mem0", mem[0], 18'h1);
    run_sweep(2'b01, 32'h1, 1'b0, bcyc, dcnt);
    check("t4_errcnt", err_count, 0);
    check("t4_errflag", err_flag, 0);
    check("t4_first", first_err_addr, 0);
    // Wrong seed: word 0 expects 2 but holds 1.
    run_sweep(2'b01, 32'h2, 1'b0, bcyc, dcnt);
    check("t4_bad_flag", err_flag, 1);
    check("t4_bad_first", first_err_addr, 0);

    // Test 5: SIGN over preloaded words, with a start pulse during busy.
    exp_q.delete();
    for (int i = 0; i < DEPTH - 1; i++) begin
      w = WID'((i * 32'h2F3B) ^ 32'h15A5A);
      exp_q.push_back({14'h0, w});
      bd_write(AW'(i), w);
    end
    exp_sig = 32'hFFFFFFFF;
    foreach (exp_q[i]) exp_sig = misr_ref(exp_sig, exp_q[i]);
    run_sweep(2'b10, 32'h0, 1'b1, bcyc, dcnt);
    check("t5_sig", signature, exp_sig);
    check("t5_busy", bcyc, 17);
    check("t5_done", dcnt, 1);
    check("t5_mem3_kept", mem[3], exp_q[3]);
    // Reserved mode is not accepted.
    @(negedge clk);
    start = 1'b1; mode = 2'b11;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    bcyc = 0;
    repeat (4) begin
      if (busy) bcyc++;
      if (done) dcnt++;
      @(negedge clk);
    end
    check("t5_rsvd_busy", bcyc, 0);
    check("t5_rsvd_done", dcnt, 0);
    check("t5_rsvd_state", dbg_state, 0);

    // Test 6: reset in the middle of FILL.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; seed = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    dcnt = 0;
    while (waddr != 4'd7 && cyc < 40) begin
      @(negedge clk);
      if (done) dcnt++;
      cyc++;
    end
    check("t6_reach_a7", waddr, 7);
    rst_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_state", dbg_state, 0);
    check("t6_waddr", waddr, 15);
    check("t6_din", din, 0);
    check("t6_sig_reset", signature, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("t6_no_done", dcnt, 0);
    run_sweep(2'b00, 32'h1234, 1'b0, bcyc, dcnt);
    check("t6_fill_busy", bcyc, 15);
    run_sweep(2'b01, 32'h1234, 1'b0, bcyc, dcnt);
    check("t6_errcnt", err_count, 0);
    check("t6_errflag", err_flag, 0);
    check("t6_sig_kept", signature, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
